// File: rtl/seq_presenter.sv
// Sequence presenter: plays a latched target sequence MSB-first on one LED,
// then debounces two answer buttons and emits single-cycle answer strobes
// for the downstream checker until the level completes or a replay is asked.
module seq_presenter #(
  parameter int unsigned SEQ_LEN     = 9,
  parameter int unsigned SHOW_CYCLES = 50000000,
  parameter int unsigned GAP_CYCLES  = 25000000,
  parameter int unsigned DEB_CYCLES  = 1000000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [SEQ_LEN-1:0] seq,
  input  logic               btn0,
  input  logic               btn1,
  input  logic               replay,
  input  logic               level_done,
  output logic               led_on,
  output logic               led_bit,
  output logic               en,
  output logic               entered,
  output logic               busy,
  output logic               done,
  output logic [1:0]         phase
);

  // One timer width covers the show, gap and debounce intervals.
  localparam int unsigned MaxShowGap = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
  localparam int unsigned MaxCyc     = (MaxShowGap > DEB_CYCLES) ? MaxShowGap : DEB_CYCLES;
  localparam int unsigned TW         = (MaxCyc > 1) ? $clog2(MaxCyc) : 1;
  localparam int unsigned IW         = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;

  localparam logic [TW-1:0] ShowLast = TW'(SHOW_CYCLES - 1);
  localparam logic [TW-1:0] GapLast  = TW'(GAP_CYCLES - 1);
  localparam logic [TW-1:0] DebLast  = TW'(DEB_CYCLES - 1);
  localparam logic [IW-1:0] IdxTop   = IW'(SEQ_LEN - 1);

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StShowOn  = 2'd1,
    StShowGap = 2'd2,
    StInput   = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [TW-1:0]      timer_q, timer_d;
  logic [SEQ_LEN-1:0] seq_q, seq_d;
  logic               en_q, en_d;
  logic               entered_q, entered_d;
  logic               done_q, done_d;

  // Button path, index 0 = btn0, index 1 = btn1.
  logic [1:0]    btn_raw;
  logic [1:0]    sync1_q, sync2_q;
  logic [1:0]    deb_q, deb_d;
  logic [1:0]    deb_prev_q;
  logic [TW-1:0] deb_cnt_q [2];
  logic [TW-1:0] deb_cnt_d [2];
  logic [1:0]    press;
  logic          single_press;

  assign btn_raw = {btn1, btn0};

  // Two-flop synchronizers for the raw asynchronous buttons.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
    end
  end

  // Debounce: accept a new level only after it has differed for DEB_CYCLES cycles.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      deb_d[i]     = deb_q[i];
      deb_cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (deb_cnt_q[i] == DebLast) begin
          deb_d[i] = sync2_q[i];
        end else begin
          deb_cnt_d[i] = deb_cnt_q[i] + TW'(1);
        end
      end
    end
  end

  // Debounced levels, their previous values and the stability counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      deb_q        <= '0;
      deb_prev_q   <= '0;
      deb_cnt_q[0] <= '0;
      deb_cnt_q[1] <= '0;
    end else begin
      deb_q        <= deb_d;
      deb_prev_q   <= deb_q;
      deb_cnt_q[0] <= deb_cnt_d[0];
      deb_cnt_q[1] <= deb_cnt_d[1];
    end
  end

  // A press is a rising edge of the debounced level; simultaneous presses cancel.
  assign press        = deb_q & ~deb_prev_q;
  assign single_press = press[0] ^ press[1];

  // Next-state logic for playback and the answer phase.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    timer_d   = timer_q;
    seq_d     = seq_q;
    en_d      = 1'b0;
    entered_d = entered_q;
    done_d    = 1'b0;

    case (state_q)
      StIdle: begin
        timer_d = '0;
        if (start) begin
          seq_d   = seq;
          idx_d   = IdxTop;
          state_d = StShowOn;
        end
      end

      StShowOn: begin
        if (timer_q == ShowLast) begin
          timer_d = '0;
          state_d = StShowGap;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

      StShowGap: begin
        if (timer_q == GapLast) begin
          timer_d = '0;
          if (idx_q == '0) begin
            state_d = StInput;
          end else begin
            idx_d   = idx_q - IW'(1);
            state_d = StShowOn;
          end
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

      StInput: begin
        timer_d = '0;
        // Exits win over a press landing in the same cycle.
        if (level_done) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end else if (replay) begin
          idx_d   = IdxTop;
          state_d = StShowOn;
        end else if (single_press) begin
          en_d      = 1'b1;
          entered_d = press[1];
        end
      end

      default: begin
        state_d = StIdle;
        timer_d = '0;
      end
    endcase
  end

  // State, playback position, latched sequence and registered strobes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      timer_q   <= '0;
      seq_q     <= '0;
      en_q      <= 1'b0;
      entered_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      timer_q   <= timer_d;
      seq_q     <= seq_d;
      en_q      <= en_d;
      entered_q <= entered_d;
      done_q    <= done_d;
    end
  end

  // Outputs decode directly from registered state, so reset forces them low at once.
  always_comb begin
    led_on  = (state_q == StShowOn);
    led_bit = led_on & seq_q[idx_q];
    busy    = (state_q != StIdle);
    phase   = state_q;
    en      = en_q;
    entered = entered_q;
    done    = done_q;
  end

endmodule

// File: tb/tb_seq_presenter.sv
// Self-checking bench for seq_presenter with small timing parameters.
module tb_seq_presenter;

  localparam int SEQ_LEN = 9;
  localparam int SHOW    = 4;
  localparam int GAP     = 2;
  localparam int DEB     = 3;
  localparam int SLOT    = SHOW + GAP;
  localparam int PLAY    = SEQ_LEN * SLOT;
  // Press-to-strobe latency: synchronizer, debounce, output register.
  localparam int PRESS_LAT = 2 + DEB + 1;

  logic               clk;
  logic               reset;
  logic               start;
  logic [SEQ_LEN-1:0] seq;
  logic               btn0;
  logic               btn1;
  logic               replay;
  logic               level_done;
  logic               led_on;
  logic               led_bit;
  logic               en;
  logic               entered;
  logic               busy;
  logic               done;
  logic [1:0]         phase;

  int checks;
  int errors;
  logic last_entered;

  seq_presenter #(
    .SEQ_LEN    (SEQ_LEN),
    .SHOW_CYCLES(SHOW),
    .GAP_CYCLES (GAP),
    .DEB_CYCLES (DEB)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .seq       (seq),
    .btn0      (btn0),
    .btn1      (btn1),
    .replay    (replay),
    .level_done(level_done),
    .led_on    (led_on),
    .led_bit   (led_bit),
    .en        (en),
    .entered   (entered),
    .busy      (busy),
    .done      (done),
    .phase     (phase)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_quiet(input string tag);
    check_eq({tag, "_phase"}, 32'(phase), 0);
    check_eq({tag, "_led_on"}, 32'(led_on), 0);
    check_eq({tag, "_led_bit"}, 32'(led_bit), 0);
    check_eq({tag, "_en"}, 32'(en), 0);
    check_eq({tag, "_done"}, 32'(done), 0);
    check_eq({tag, "_busy"}, 32'(busy), 0);
  endtask

  // Called in the first lit cycle; checks every playback cycle against the slot arithmetic.
  task automatic run_playback(input logic [SEQ_LEN-1:0] ref_seq, input bit pokes);
    int start_k;
    int btn_k;
    int ld_k;
    int rp_k;
    start_k = SLOT * int'($urandom_range(0, SEQ_LEN - 1)) + SHOW + 1;
    btn_k   = SLOT * int'($urandom_range(0, 4)) + 1;
    ld_k    = int'($urandom_range(1, PLAY));
    rp_k    = int'($urandom_range(1, PLAY));
    for (int k = 1; k <= PLAY; k++) begin
      int  slot;
      int  off;
      bit  lit;
      slot = (k - 1) / SLOT;
      off  = (k - 1) % SLOT;
      lit  = (off < SHOW);
      check_eq("pb_phase", 32'(phase), lit ? 1 : 2);
      check_eq("pb_led_on", 32'(led_on), 32'(lit));
      if (lit) check_eq("pb_led_bit", 32'(led_bit), 32'(ref_seq[SEQ_LEN - 1 - slot]));
      check_eq("pb_en", 32'(en), 0);
      check_eq("pb_done", 32'(done), 0);
      check_eq("pb_busy", 32'(busy), 1);
      if (pokes) begin
        start      = (k == start_k);
        if (k == start_k) seq = ~ref_seq;
        btn1       = (k >= btn_k) && (k < btn_k + 10);
        level_done = (k == ld_k);
        replay     = (k == rp_k);
      end
      tick();
    end
    start      = 1'b0;
    btn1       = 1'b0;
    level_done = 1'b0;
    replay     = 1'b0;
    check_eq("pb_enter_input", 32'(phase), 3);
    check_eq("pb_input_led", 32'(led_on), 0);
  endtask

  // which: 0 = btn0, 1 = btn1, 2 = both together. Held 10 cycles from t=0.
  task automatic press_check(input int which);
    int exp_t;
    exp_t = (which == 2) ? -1 : PRESS_LAT;
    btn0 = (which == 0) || (which == 2);
    btn1 = (which == 1) || (which == 2);
    for (int t = 1; t <= 22; t++) begin
      tick();
      if (t == 10) begin
        btn0 = 1'b0;
        btn1 = 1'b0;
      end
      check_eq("ans_en", 32'(en), 32'(t == exp_t));
      if (t == exp_t) last_entered = (which == 1);
      check_eq("ans_entered", 32'(entered), 32'(last_entered));
      check_eq("ans_phase", 32'(phase), 3);
    end
  endtask

  task automatic start_play(input logic [SEQ_LEN-1:0] s, input bit pokes);
    seq   = s;
    start = 1'b1;
    tick();
    start = 1'b0;
    run_playback(s, pokes);
  endtask

  task automatic exit_done(input bit with_replay);
    level_done = 1'b1;
    replay     = with_replay;
    btn0       = 1'b0;
    tick();
    level_done = 1'b0;
    replay     = 1'b0;
    check_eq("exit_done", 32'(done), 1);
    check_eq("exit_phase", 32'(phase), 0);
    check_eq("exit_busy", 32'(busy), 0);
    tick();
    check_eq("exit_done_width", 32'(done), 0);
    check_eq("exit_stay_idle", 32'(phase), 0);
  endtask

  initial begin
    logic [SEQ_LEN-1:0] s;
    checks       = 0;
    errors       = 0;
    last_entered = 1'b0;
    reset        = 1'b0;
    start        = 1'b0;
    seq          = '0;
    btn0         = 1'b0;
    btn1         = 1'b0;
    replay       = 1'b0;
    level_done   = 1'b0;

    #1;
    check_quiet("rst");
    check_eq("rst_entered", 32'(entered), 0);
    repeat (3) tick();
    reset = 1'b1;
    tick();
    check_quiet("post_rst");

    // Alternating pattern first, with ignored inputs poked during playback.
    start_play(9'b101010101, 1'b1);
    press_check(1);
    press_check(0);
    for (int r = 0; r < 4; r++) press_check(int'($urandom_range(0, 1)));

    // Bouncing btn0 never settles long enough.
    for (int t = 0; t < 20; t++) begin
      btn0 = ((t / 2) % 2) == 0;
      tick();
      check_eq("bounce_en", 32'(en), 0);
    end
    btn0 = 1'b0;
    for (int t = 0; t < 10; t++) begin
      tick();
      check_eq("bounce_tail_en", 32'(en), 0);
    end
    press_check(2);

    exit_done(1'b1);

    // Random sequence, then replay alone reuses it.
    s = SEQ_LEN'($urandom);
    start_play(s, 1'b1);
    press_check(int'($urandom_range(0, 2)));
    replay = 1'b1;
    tick();
    replay = 1'b0;
    check_eq("replay_phase", 32'(phase), 1);
    check_eq("replay_bit", 32'(led_bit), 32'(s[SEQ_LEN-1]));
    run_playback(s, 1'b0);
    press_check(int'($urandom_range(0, 1)));
    exit_done(1'b0);

    // Reset during the lit slot of bit 4.
    s     = SEQ_LEN'($urandom);
    seq   = s;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4 * SLOT + 1) tick();
    check_eq("mid_lit", 32'(led_on), 1);
    check_eq("mid_bit", 32'(led_bit), 32'(s[4]));
    reset = 1'b0;
    #1;
    check_quiet("mid_rst");
    check_eq("mid_rst_entered", 32'(entered), 0);
    last_entered = 1'b0;
    tick();
    reset = 1'b1;
    check_quiet("mid_rel");
    tick();
    check_quiet("mid_after");
    s = SEQ_LEN'($urandom);
    start_play(s, 1'b0);
    press_check(1);
    exit_done(1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
